// File: rtl/mdr_xfer_reg_if.sv
// Bus/memory handshake bundle for mdr_xfer_reg.
// slave = register side, master = control unit / memory side.
interface mdr_xfer_reg_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              mdr_in;
  logic              mem_rd;
  logic              mem_wr;
  logic [1:0]        size;
  logic              sign;
  logic [DATA_W-1:0] mdata_in;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mdata_out;
  logic [DATA_W-1:0] Q;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  BusMuxOut, mdr_in, mem_rd, mem_wr, size, sign, mdata_in, mem_ready,
    output mem_req, mem_we, mdata_out, Q, busy, done, err
  );

  modport master (
    output BusMuxOut, mdr_in, mem_rd, mem_wr, size, sign, mdata_in, mem_ready,
    input  mem_req, mem_we, mdata_out, Q, busy, done, err
  );
endinterface

// File: rtl/mdr_xfer_reg.sv
// Memory data register with req/ready memory handshake and optional timeout.
// Optional feature macro MDR_SUBWORD_EXT_EN: byte/half extraction with sign/zero extension on reads.
module mdr_xfer_reg #(
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input logic            clock,
  input logic            reset,
  mdr_xfer_reg_if.slave  bus
);
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int LAST  = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_q;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_timeout;

`ifdef MDR_SUBWORD_EXT_EN
  logic [1:0] r_size;
  logic       r_sign;

  function automatic logic [DATA_W-1:0] ext_rd(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sz,
                                               input logic sg);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (sz)
      2'b00:   ext_rd = sg ? DATA_W'(b) : DATA_W'(d[7:0]);
      2'b01:   ext_rd = sg ? DATA_W'(h) : DATA_W'(d[15:0]);
      default: ext_rd = d;
    endcase
  endfunction

  assign w_rd_val = ext_rd(bus.mdata_in, r_size, r_sign);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{bus.size, bus.sign};
  assign w_rd_val     = bus.mdata_in;
`endif

  // Abort on the last permitted wait cycle; ready on that same edge still wins.
  assign w_timeout = (WAIT_MAX > 0) && (r_cnt == CNT_W'(LAST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef MDR_SUBWORD_EXT_EN
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mem_rd || bus.mem_wr) begin
            r_state <= bus.mem_rd ? RD_WAIT : WR_WAIT;
            r_err   <= 1'b0;
            r_cnt   <= '0;
`ifdef MDR_SUBWORD_EXT_EN
            r_size  <= bus.size;
            r_sign  <= bus.sign;
`endif
          end else if (bus.mdr_in) begin
            r_q <= bus.BusMuxOut;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (bus.mem_ready) begin
            if (r_state == RD_WAIT) r_q <= w_rd_val;
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else if (WAIT_MAX > 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_we    = (r_state == WR_WAIT);
  assign bus.busy      = (r_state != IDLE);
  assign bus.mdata_out = r_q;
  assign bus.Q         = r_q;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_mdr_xfer_reg.sv
// Directed plus randomized bench for mdr_xfer_reg against a transaction-level model.
// Works with or without MDR_SUBWORD_EXT_EN defined.
module tb_mdr_xfer_reg;
  localparam int DW = 32;
  localparam int WM = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q;

  always #5 clk = ~clk;

  mdr_xfer_reg_if #(.DATA_W(DW)) bus_if ();

  mdr_xfer_reg #(.DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    longint v;
`ifdef MDR_SUBWORD_EXT_EN
    if (sz == 2'b00) begin
      v = longint'(d) % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      v = longint'(d) % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(d);
    end
`else
    v = longint'(d);
`endif
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    bus_if.mdr_in    = 1'b0;
    bus_if.mem_rd    = 1'b0;
    bus_if.mem_wr    = 1'b0;
    bus_if.mem_ready = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    bus_if.BusMuxOut = '0;
    bus_if.size      = 2'b10;
    bus_if.sign      = 1'b0;
    bus_if.mdata_in  = '0;
    clear_cmds();
    repeat (3) tick();

    // reset state
    chk("rst_q", bus_if.Q, 32'h0);
    chk("rst_busy", {31'b0, bus_if.busy}, 32'h0);
    chk("rst_done", {31'b0, bus_if.done}, 32'h0);
    chk("rst_err", {31'b0, bus_if.err}, 32'h0);
    chk("rst_we", {31'b0, bus_if.mem_we}, 32'h0);
    chk("rst_mdout", bus_if.mdata_out, 32'h0);
    rst = 1'b0;
    tick();

    // bus load
    bus_if.BusMuxOut = 32'hDEADBEEF;
    bus_if.mdr_in    = 1'b1;
    tick();
    clear_cmds();
    exp_q = 32'hDEADBEEF;
    chk("load_q", bus_if.Q, exp_q);
    chk("load_busy", {31'b0, bus_if.busy}, 32'h0);

    // signed byte read, ready three cycles after command
    bus_if.size = 2'b00; bus_if.sign = 1'b1; bus_if.mem_rd = 1'b1;
    tick();
    clear_cmds();
    bus_if.size = 2'b10; bus_if.sign = 1'b0;
    chk("rd_req", {31'b0, bus_if.mem_req}, 32'h1);
    chk("rd_we", {31'b0, bus_if.mem_we}, 32'h0);
    bus_if.mdata_in = 32'h000000F0;
    tick(); tick();
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    exp_q = model_ext(32'h000000F0, 2'b00, 1'b1);
    chk("rd_done", {31'b0, bus_if.done}, 32'h1);
    chk("rd_busy_at_done", {31'b0, bus_if.busy}, 32'h0);
    chk("rd_q", bus_if.Q, exp_q);
    tick();
    chk("rd_done_pulse", {31'b0, bus_if.done}, 32'h0);

    // write transaction; bus loads ignored while waiting
    bus_if.BusMuxOut = 32'h12345678; bus_if.mdr_in = 1'b1;
    tick();
    clear_cmds();
    exp_q = 32'h12345678;
    bus_if.mem_wr = 1'b1;
    tick();
    clear_cmds();
    chk("wr_req", {31'b0, bus_if.mem_req}, 32'h1);
    chk("wr_we", {31'b0, bus_if.mem_we}, 32'h1);
    chk("wr_mdout", bus_if.mdata_out, exp_q);
    bus_if.BusMuxOut = 32'hAAAA5555; bus_if.mdr_in = 1'b1;
    tick();
    clear_cmds();
    chk("wr_ignore_load", bus_if.Q, exp_q);
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    chk("wr_done", {31'b0, bus_if.done}, 32'h1);
    chk("wr_q", bus_if.Q, exp_q);

    // read issued in the done cycle, then left to time out
    bus_if.mem_rd = 1'b1;
    tick();
    clear_cmds();
    chk("tmo_accept_in_done", {31'b0, bus_if.busy}, 32'h1);
    busy_cycles = 1;
    for (int i = 0; i < 30 && bus_if.busy; i++) begin
      tick();
      if (bus_if.busy) busy_cycles++;
    end
    chk("tmo_busy_cycles", busy_cycles, WM);
    chk("tmo_err", {31'b0, bus_if.err}, 32'h1);
    chk("tmo_done", {31'b0, bus_if.done}, 32'h0);
    chk("tmo_q", bus_if.Q, exp_q);
    bus_if.mem_rd = 1'b1;
    tick();
    clear_cmds();
    chk("tmo_err_cleared", {31'b0, bus_if.err}, 32'h0);

    // ready on the last permitted wait cycle completes normally
    bus_if.mdata_in = 32'h0BADF00D;
    repeat (WM - 1) tick();
    chk("edge_still_busy", {31'b0, bus_if.busy}, 32'h1);
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    exp_q = 32'h0BADF00D;
    chk("edge_done", {31'b0, bus_if.done}, 32'h1);
    chk("edge_err", {31'b0, bus_if.err}, 32'h0);
    chk("edge_q", bus_if.Q, exp_q);

    // simultaneous commands: read wins
    bus_if.mem_rd = 1'b1; bus_if.mem_wr = 1'b1; bus_if.mdr_in = 1'b1;
    bus_if.BusMuxOut = 32'hCAFEF00D;
    tick();
    clear_cmds();
    chk("prio_we", {31'b0, bus_if.mem_we}, 32'h0);
    chk("prio_busy", {31'b0, bus_if.busy}, 32'h1);
    chk("prio_no_load", bus_if.Q, exp_q);
    bus_if.mdata_in = 32'h76543210; bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;
    exp_q = 32'h76543210;
    chk("prio_q", bus_if.Q, exp_q);

    // reset in the middle of a read
    bus_if.mem_rd = 1'b1;
    tick();
    clear_cmds();
    #2 rst = 1'b1;
    #1;
    exp_q = 32'h0;
    chk("mid_rst_q", bus_if.Q, exp_q);
    chk("mid_rst_busy", {31'b0, bus_if.busy}, 32'h0);
    chk("mid_rst_done", {31'b0, bus_if.done}, 32'h0);
    bus_if.mdata_in = 32'h11112222; bus_if.mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus_if.mem_ready = 1'b0;
    chk("post_rst_q", bus_if.Q, exp_q);
    chk("post_rst_done", {31'b0, bus_if.done}, 32'h0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      int op, dly;
      logic [31:0] d;
      logic [1:0] sz;
      logic sg;
      op = $urandom_range(0, 2);
      dly = $urandom_range(0, 18);
      d = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      if (op == 0) begin
        bus_if.BusMuxOut = d; bus_if.mdr_in = 1'b1;
        tick();
        clear_cmds();
        exp_q = d;
        chk("rnd_load_q", bus_if.Q, exp_q);
      end else begin
        bus_if.size = sz; bus_if.sign = sg;
        if (op == 1) bus_if.mem_rd = 1'b1; else bus_if.mem_wr = 1'b1;
        tick();
        clear_cmds();
        bus_if.size = ~sz; bus_if.sign = ~sg;
        chk("rnd_we", {31'b0, bus_if.mem_we}, {31'b0, op == 2});
        chk("rnd_mdout", bus_if.mdata_out, exp_q);
        if (dly < WM) begin
          for (int k = 0; k < dly; k++) begin
            bus_if.BusMuxOut = $urandom; bus_if.mdr_in = 1'($urandom_range(0, 1));
            tick();
          end
          clear_cmds();
          chk("rnd_busy_wait", {31'b0, bus_if.busy}, 32'h1);
          bus_if.mdata_in = d; bus_if.mem_ready = 1'b1;
          tick();
          bus_if.mem_ready = 1'b0;
          if (op == 1) exp_q = model_ext(d, sz, sg);
          chk("rnd_done", {31'b0, bus_if.done}, 32'h1);
          chk("rnd_q", bus_if.Q, exp_q);
        end else begin
          repeat (WM) tick();
          chk("rnd_tmo_err", {31'b0, bus_if.err}, 32'h1);
          chk("rnd_tmo_done", {31'b0, bus_if.done}, 32'h0);
          chk("rnd_tmo_q", bus_if.Q, exp_q);
        end
        tick();
        chk("rnd_idle", {31'b0, bus_if.busy}, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
